// File: rtl/pwm_audio_out.sv
// PWM audio output stage.
// Buffers signed 16-bit samples in a small FIFO, converts each one to an
// offset-binary duty word and drives a single-bit PWM stream whose period is
// 2^PWM_BITS counter ticks, one tick every CLK_DIV clocks.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | amplifier shut down, PWM counter parked, FIFO still accepts
// S_RUN  | amplifier released, PWM running, FIFO popped per period
module pwm_audio_out #(
  parameter int PWM_BITS   = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          underrun_clr,
  output logic                          pwm_out,
  output logic                          audio_sd,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0]       DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]       DIV_ONE   = DW'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MID  = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [AW-1:0]       PTR_ONE   = AW'(1);
  localparam logic [LW-1:0]       LVL_ONE   = LW'(1);
  localparam logic [LW-1:0]       LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]       LVL_EMPTY = '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                underrun_q, underrun_d;
  logic                pwm_q, pwm_d;
  logic [PWM_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                running;
  logic                tick;
  logic                boundary;
  logic                push;
  logic                pop;
  logic                underrun_set;
  logic [15:0]         sample_off;
  logic [PWM_BITS-1:0] duty_in;

  // Samples are stored already converted to offset-binary duty words.
  assign sample_off = sample_in ^ 16'h8000;
  assign duty_in    = sample_off[15 -: PWM_BITS];

  // Ready depends on the registered level only, never on this cycle's pop,
  // so a full FIFO stalls the source until the pop has been committed.
  assign sample_ready = (level_q < LVL_FULL);
  assign push         = sample_valid && sample_ready;

  // The PWM only advances while RUN is held; the cycle enable drops is
  // already treated as idle so a coinciding boundary is abandoned.
  assign running      = (state_q == S_RUN) && enable;
  assign tick         = running && (div_q == DIV_LAST);
  assign boundary     = tick && (cnt_q == CNT_MAX);
  assign pop          = boundary && (level_q != LVL_EMPTY);
  assign underrun_set = boundary && (level_q == LVL_EMPTY);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable alone selects the mode every cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable)  state_d = S_RUN;
      S_RUN:   if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tick divider and PWM counter, parked whenever the PWM is not running.
  always_comb begin
    div_d = '0;
    cnt_d = CNT_MAX;
    if (running) begin
      cnt_d = cnt_q;
      if (tick) begin
        div_d = '0;
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end
  end

  // Duty reload at each period boundary: FIFO head or midscale on underrun.
  always_comb begin
    duty_d = duty_q;
    if (pop) begin
      duty_d = mem_q[rd_ptr_q];
    end else if (underrun_set) begin
      duty_d = DUTY_MID;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Sticky underrun flag; a new underrun wins over a coinciding clear.
  always_comb begin
    underrun_d = underrun_q;
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // Compare against next-cycle counter and duty so pwm_out lines up with the
  // period boundary instead of trailing it by one clock.
  always_comb begin
    pwm_d = (state_d == S_RUN) && (cnt_d < duty_d);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      cnt_q      <= CNT_MAX;
      duty_q     <= DUTY_MID;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      pwm_q      <= pwm_d;
    end
  end

  // Sample storage; contents are don't-care once the level says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= duty_in;
    end
  end

  assign pwm_out    = pwm_q;
  assign audio_sd   = (state_q == S_RUN);
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Bench for pwm_audio_out with default parameters (8-bit PWM, /4 tick, 4-deep FIFO).
module tb_pwm_audio_out;

  localparam int CLK_DIV     = 4;
  localparam int MID         = 128;
  localparam int PERIOD_CLKS = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        underrun_clr;
  logic        pwm_out;
  logic        audio_sd;
  logic        underrun;
  logic [2:0]  fifo_level;

  pwm_audio_out #(
    .PWM_BITS   (8),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .underrun_clr (underrun_clr),
    .pwm_out      (pwm_out),
    .audio_sd     (audio_sd),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  bit exp_under;

  typedef struct {
    logic [15:0] sample;
    int          duty;
  } vec_t;

  vec_t tbl[8];
  vec_t idle_v[3];
  vec_t hold_v[5];
  vec_t rst_v[3];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Called on the negedge just before a period boundary; returns on the
  // negedge just before the next one.
  // mode 0: no push; 1: push lands on the boundary edge;
  // 2: a stalled sample is already held and goes in one clock after the pop.
  task automatic run_period(input int mode, input logic [15:0] s, input int d,
                            input bit clr_bnd, input bit clr_mid);
    int exp_duty;
    int highs;
    if (mode == 1) begin
      sample_in    = s;
      sample_valid = 1'b1;
    end
    if (clr_bnd) underrun_clr = 1'b1;
    if (exp_q.size() > 0) begin
      exp_duty = exp_q.pop_front();
      if (clr_bnd) exp_under = 1'b0;
    end else begin
      exp_duty  = MID;
      exp_under = 1'b1;
    end
    if (mode == 1) exp_q.push_back(d);
    highs = 0;
    for (int c = 0; c < PERIOD_CLKS; c++) begin
      @(negedge clk);
      if (pwm_out) highs++;
      if (c == 0) begin
        underrun_clr = 1'b0;
        if (mode == 1) sample_valid = 1'b0;
        chk("level_after_boundary", int'(fifo_level), exp_q.size());
        if (mode == 2) chk("ready_after_pop", int'(sample_ready), 1);
      end
      if (c == 1 && mode == 2) begin
        exp_q.push_back(d);
        sample_valid = 1'b0;
        chk("stalled_sample_accepted", int'(fifo_level), exp_q.size());
      end
      if (clr_mid && c == 100) underrun_clr = 1'b1;
      if (clr_mid && c == 101) begin
        underrun_clr = 1'b0;
        exp_under    = 1'b0;
        chk("underrun_lone_clr", int'(underrun), 0);
      end
    end
    chk("period_high_clks", highs, exp_duty * CLK_DIV);
    chk("underrun_flag", int'(underrun), int'(exp_under));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h4000, 192};
    tbl[1] = '{16'hC000, 64};
    tbl[2] = '{16'hFFFF, 127};
    tbl[3] = '{16'h0100, 129};
    tbl[4] = '{16'h80FF, 0};
    tbl[5] = '{16'h7F00, 255};
    tbl[6] = '{16'h1234, 146};
    tbl[7] = '{16'hA5A5, 37};
    idle_v[0] = '{16'h0000, 128};
    idle_v[1] = '{16'h7FFF, 255};
    idle_v[2] = '{16'h8000, 0};
    hold_v[0] = '{16'h2000, 160};
    hold_v[1] = '{16'hE000, 96};
    hold_v[2] = '{16'h0010, 128};
    hold_v[3] = '{16'hF000, 112};
    hold_v[4] = '{16'h6000, 224};
    rst_v[0]  = '{16'h1111, 145};
    rst_v[1]  = '{16'h2222, 162};
    rst_v[2]  = '{16'h3333, 179};

    rst_n        = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    underrun_clr = 1'b0;
    exp_under    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_audio_sd", int'(audio_sd), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_sample_ready", int'(sample_ready), 1);
    chk("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload three samples while idle.
    for (int k = 0; k < 3; k++) begin
      sample_in    = idle_v[k].sample;
      sample_valid = 1'b1;
      @(negedge clk);
      exp_q.push_back(idle_v[k].duty);
    end
    sample_valid = 1'b0;
    @(negedge clk);
    chk("idle_preload_level", int'(fifo_level), 3);
    chk("idle_audio_sd", int'(audio_sd), 0);
    chk("idle_pwm_out", int'(pwm_out), 0);

    enable = 1'b1;
    @(negedge clk);
    chk("run_audio_sd", int'(audio_sd), 1);
    repeat (3) @(negedge clk);
    chk("no_pop_before_first_tick", int'(fifo_level), 3);
    chk("pwm_low_before_first_tick", int'(pwm_out), 0);

    // Periods with 0x0000, 0x7FFF, 0x8000: level 2 -> 1 -> 0.
    repeat (3) run_period(0, 16'h0, 0, 1'b0, 1'b0);
    // Empty FIFO at the boundary with a coinciding push: midscale + underrun,
    // the pushed sample waits for the next period. A lone clear follows.
    run_period(1, tbl[0].sample, tbl[0].duty, 1'b0, 1'b1);
    // Keep pace: one push per boundary, pointers wrap repeatedly.
    for (int i = 1; i < 8; i++) begin
      run_period(1, tbl[i].sample, tbl[i].duty, 1'b0, 1'b0);
    end
    run_period(0, 16'h0, 0, 1'b0, 1'b0);
    // Underrun with a coinciding clear: set wins.
    run_period(0, 16'h0, 0, 1'b1, 1'b0);

    // Back to idle, fill past capacity with a held source.
    enable = 1'b0;
    @(negedge clk);
    chk("disable_audio_sd", int'(audio_sd), 0);
    chk("disable_pwm_out", int'(pwm_out), 0);
    for (int k = 0; k < 4; k++) begin
      sample_in    = hold_v[k].sample;
      sample_valid = 1'b1;
      @(negedge clk);
      exp_q.push_back(hold_v[k].duty);
      chk("idle_fill_level", int'(fifo_level), exp_q.size());
    end
    sample_in = hold_v[4].sample;
    repeat (3) @(negedge clk);
    chk("full_ready_low", int'(sample_ready), 0);
    chk("full_level", int'(fifo_level), 4);
    enable = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("full_no_early_pop", int'(fifo_level), 4);
    run_period(2, hold_v[4].sample, hold_v[4].duty, 1'b0, 1'b1);
    repeat (4) run_period(0, 16'h0, 0, 1'b0, 1'b0);

    // Three pushes, the first one on an underrun boundary, then reset mid-period.
    sample_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample_in = rst_v[k].sample;
      @(negedge clk);
      chk("prereset_level", int'(fifo_level), k + 1);
    end
    sample_valid = 1'b0;
    chk("prereset_underrun", int'(underrun), 1);
    repeat (8) @(negedge clk);
    chk("prereset_pwm_high", int'(pwm_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm_out", int'(pwm_out), 0);
    chk("async_rst_audio_sd", int'(audio_sd), 0);
    chk("async_rst_fifo_level", int'(fifo_level), 0);
    chk("async_rst_sample_ready", int'(sample_ready), 1);
    chk("async_rst_underrun", int'(underrun), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_level", int'(fifo_level), 0);
    chk("post_rst_audio_sd", int'(audio_sd), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
PWM_AUDIO_OUT -- requirements
Module: pwm_audio_out

Interface
REQ-001 SHALL provide parameter PWM_BITS, default 8, the PWM resolution in bits and the duty width (legal 4..12).
REQ-002 SHALL provide parameter CLK_DIV, default 4, the number of clk cycles per PWM counter tick (legal >=1).
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, the sample buffer entries (power of 2, >=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1 bit: system clock, all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: run PWM when high, idle when low.
REQ-008 SHALL have port sample_in, input, 16 bits: signed two's-complement mixed sample.
REQ-009 SHALL have port sample_valid, input, 1 bit: sample_in is valid this cycle.
REQ-010 SHALL have port sample_ready, output, 1 bit: the FIFO can accept a sample.
REQ-011 SHALL have port underrun_clr, input, 1 bit: clears the sticky underrun flag.
REQ-012 SHALL have port pwm_out, output, 1 bit: registered PWM audio bit.
REQ-013 SHALL have port audio_sd, output, 1 bit: amplifier shutdown-release, high in RUN.
REQ-014 SHALL have port underrun, output, 1 bit: sticky flag for an empty FIFO at a period boundary.
REQ-015 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 SHALL accept a sample on a clk edge where sample_valid && sample_ready; sample_ready SHALL equal (fifo_level < FIFO_DEPTH), derived from registered state only.
REQ-017 SHALL hold sample_in unchanged when sample_valid is high and sample_ready is low; the sample SHALL NOT be lost and SHALL be accepted once ready rises.
REQ-018 SHALL convert each sample to duty = (sample_in XOR 16'h8000)[15:16-PWM_BITS] (offset binary, top PWM_BITS bits), so that 16'h0000->128, 16'h7FFF->255 and 16'h8000->0 for PWM_BITS=8.
REQ-019 SHALL have two states: IDLE (enable=0) and RUN (enable=1), with transitions evaluated every clk.
REQ-020 In IDLE, SHALL hold tick divider=0, pwm_cnt=2^PWM_BITS-1, pwm_out=0, audio_sd=0; FIFO contents SHALL be retained and pushes still accepted.
REQ-021 In RUN, SHALL assert audio_sd=1 from the first RUN cycle and pulse an internal tick every CLK_DIV clk cycles, the first tick occurring CLK_DIV cycles after entering RUN.
REQ-022 On each tick, SHALL increment pwm_cnt modulo 2^PWM_BITS.
REQ-023 On a tick where pwm_cnt wraps to 0 (period boundary), SHALL pop the FIFO head into the duty register if the FIFO is non-empty.
REQ-024 On a period boundary with an empty FIFO, SHALL load duty=2^(PWM_BITS-1) (midscale) and set underrun.
REQ-025 SHALL register pwm_out = (pwm_cnt < duty) in RUN, giving exactly duty ticks high per 2^PWM_BITS-tick period.
REQ-026 SHALL give a push and a pop in the same cycle a net fifo_level change of 0; a push into an empty FIFO SHALL NOT bypass to a same-cycle pop, so the boundary takes midscale and flags underrun.
REQ-027 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with no corruption at wrap.
REQ-028 SHALL clear underrun when underrun_clr is high; if set and clear coincide, set SHALL win.
REQ-029 On enable falling mid-period, SHALL enter IDLE next cycle, abandon the period, and not pop.

Reset
REQ-030 On rst_n=0, SHALL immediately and asynchronously force state=IDLE, FIFO empty (fifo_level=0), sample_ready=1, duty=2^(PWM_BITS-1), pwm_cnt=2^PWM_BITS-1, divider=0, pwm_out=0, audio_sd=0, underrun=0.
REQ-031 SHALL discard all buffered samples on reset asserted mid-operation; operation resumes only per REQ-019..REQ-025 after rst_n rises.

Verification
REQ-032 Defaults; push 16'h0000 while IDLE, raise enable -> audio_sd=1 next cycle; first pop at cycle 4, then pwm_out high 128 of 256 ticks (512 of 1024 clks).
REQ-033 Push 16'h7FFF then 16'h8000 -> period 1 high 255 ticks, period 2 pwm_out constantly 0, fifo_level 2->1->0.
REQ-034 Hold sample_valid=1 with 5 distinct samples while IDLE -> sample_ready=0 after 4, fifo_level=4, 5th accepted only after the first pop; output order is preserved.
REQ-035 Empty FIFO at a boundary -> duty=128, underrun=1 sticky; underrun_clr coinciding with a new underrun -> underrun stays 1; a lone clr -> 0.
REQ-036 Drop rst_n mid-period with fifo_level=3 -> same-instant pwm_out=0, audio_sd=0, fifo_level=0, sample_ready=1.
REQ-037 Fill and drain 10 samples so pointers wrap twice -> duties match the inputs in order, with no underrun while pushes keep pace.
